// File: rtl/frame_stream_pkg.sv
// rtl/frame_stream_pkg.sv - shared frame IDs, write FSM state type and saturating increment
package frame_stream_pkg;

    localparam logic [7:0] HEADER_ID = 8'hAA;
    localparam logic [7:0] FOOTER_ID = 8'h55;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

    // Holds at max_value instead of wrapping; callers pass a zero-extended all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/frame_axis_streamer_if.sv
// rtl/frame_axis_streamer_if.sv - AXI4-Stream style data/valid/last/ready bundle
interface frame_axis_streamer_if #(
    parameter int TDATA_WIDTH = 256
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_fifo_sync.sv
// rtl/stream_fifo_sync.sv - synchronous RAM FIFO with free count and registered FWFT output
module stream_fifo_sync #(
    parameter int DATA_WIDTH = 257,
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DEPTH_LOG2:0]   free,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   ram_count;
    logic [DEPTH_LOG2:0]   occupancy;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    logic out_fire;
    logic out_load;
    logic ram_rd;

    // Occupancy covers RAM plus both pipeline stages, so free space is only returned at the handshake.
    assign free     = DEPTH_W - occupancy;
    assign out_fire = out_valid & out_ready;
    assign out_load = s1_valid & (~out_valid | out_ready);
    assign ram_rd   = (ram_count != '0) & (~s1_valid | out_load);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
        if (ram_rd) begin
            s1_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            occupancy <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            ram_count <= ram_count + (DEPTH_LOG2 + 1)'(wr_en) - (DEPTH_LOG2 + 1)'(ram_rd);
            occupancy <= occupancy + (DEPTH_LOG2 + 1)'(wr_en) - (DEPTH_LOG2 + 1)'(out_fire);
            s1_valid  <= ram_rd | (s1_valid & ~out_load);
            if (out_load) begin
                out_data <= s1_data;
            end
            out_valid <= out_load | (out_valid & ~out_fire);
        end
    end

endmodule

// File: rtl/frame_axis_streamer.sv
// rtl/frame_axis_streamer.sv - store-and-forward frame buffer to AXIS master; FRAME_CNT_EN adds frame_cnt
module frame_axis_streamer
    import frame_stream_pkg::*;
#(
    parameter int TDATA_WIDTH     = 256,
    parameter int MAX_FRAME_WORDS = 52,
    parameter int FIFO_DEPTH_LOG2 = 7,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [TDATA_WIDTH-1:0]    din,
    input  logic                      din_valid,
    frame_axis_streamer_if.master     m_axis,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    output logic [DROP_CNT_WIDTH-1:0] trunc_cnt
`ifdef FRAME_CNT_EN
    ,
    output logic [31:0]               frame_cnt
`endif
);
    localparam int WCW = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [WCW-1:0] LAST_IDX = WCW'(MAX_FRAME_WORDS - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] ROOM_NEEDED = (FIFO_DEPTH_LOG2 + 1)'(MAX_FRAME_WORDS);
    localparam logic [31:0] CNT_MAX = 32'({DROP_CNT_WIDTH{1'b1}});

    wr_state_t                state;
    logic [WCW-1:0]           word_cnt;
    logic [FIFO_DEPTH_LOG2:0] free;
    logic                     is_hdr;
    logic                     is_ftr;
    logic                     has_room;
    logic                     wr_en;
    logic                     wr_last;
    logic [TDATA_WIDTH:0]     fifo_out;
    logic                     fifo_valid;

    assign is_hdr   = din[TDATA_WIDTH-1 -: 8] == HEADER_ID;
    assign is_ftr   = din[TDATA_WIDTH-1 -: 8] == FOOTER_ID;
    assign has_room = free >= ROOM_NEEDED;

    // Write strobe is decided in the same cycle as the word so the admission check sees every prior write.
    always_comb begin
        wr_en   = 1'b0;
        wr_last = 1'b0;
        if (din_valid && !reset) begin
            case (state)
                ACCEPT: begin
                    wr_en   = 1'b1;
                    wr_last = is_hdr | is_ftr | (word_cnt == LAST_IDX);
                end
                default: begin
                    wr_en = is_hdr & has_room;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else if (din_valid) begin
            case (state)
                IDLE, DISCARD: begin
                    if (is_hdr) begin
                        if (has_room) begin
                            state    <= ACCEPT;
                            word_cnt <= WCW'(1);
                        end else begin
                            drop_cnt <= DROP_CNT_WIDTH'(sat_inc(32'(drop_cnt), CNT_MAX));
                            state    <= DISCARD;
                        end
                    end else if (is_ftr) begin
                        state <= IDLE;
                    end
                end
                ACCEPT: begin
                    word_cnt <= word_cnt + WCW'(1);
                    // A header inside an open frame closes it as a truncation.
                    if (is_hdr || (!is_ftr && word_cnt == LAST_IDX)) begin
                        trunc_cnt <= DROP_CNT_WIDTH'(sat_inc(32'(trunc_cnt), CNT_MAX));
                        state     <= DISCARD;
                    end else if (is_ftr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    stream_fifo_sync #(
        .DATA_WIDTH (TDATA_WIDTH + 1),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   ({wr_last, din}),
        .free      (free),
        .out_data  (fifo_out),
        .out_valid (fifo_valid),
        .out_ready (m_axis.tready)
    );

    assign m_axis.tdata  = fifo_out[TDATA_WIDTH-1:0];
    assign m_axis.tlast  = fifo_out[TDATA_WIDTH];
    assign m_axis.tvalid = fifo_valid;

`ifdef FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (fifo_valid && m_axis.tready && fifo_out[TDATA_WIDTH]) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end
`endif

endmodule
